// File: rtl/fm_cycle_sched.sv
// ---------------------------------------------------------------------------
// fm_cycle_sched -- frame-memory access scheduler.
//
// Time is cut into fixed CYCLE_LEN-clock slots. Each slot is granted to at
// most one requester: panel display read, input-video burst write, or CPU.
// The grant is decided on the last clock of the previous slot and issued as
// a single command strobe on the first clock of the slot. The block also
// owns the write-bank bit (frame_alt) and prepends it to every address.
//
// Optional build macro: FM_SCHED_STAT_EN
//   When defined, per-frame slot-usage counters are added
//   (stat_rd, stat_iv, stat_cpu, stat_idle). When undefined the ports and
//   counters are absent and every other behaviour is unchanged.
// ---------------------------------------------------------------------------
module fm_cycle_sched #(
  parameter int CYCLE_LEN = 72,
  parameter int ADV       = 8,
  parameter int CPU_MAXW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rd_req,
  input  logic [15:0] rd_adrs,
  input  logic        iv_wr_req,
  input  logic [15:0] iv_wr_adrs,
  input  logic        iv_frame_end,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_adrs,
  output logic        fm_cycle_stp_adv,
  output logic        fm_cycle_stp,
  output logic [2:0]  grant,
  output logic        fm_cmd_valid,
  output logic        fm_cmd_we,
  output logic [16:0] fm_cmd_adrs,
  output logic        cpu_ack,
  output logic        frame_alt
`ifdef FM_SCHED_STAT_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_iv,
  output logic [15:0] stat_cpu,
  output logic [15:0] stat_idle
`endif
);

  localparam int CC_W   = $clog2(CYCLE_LEN);
  localparam int WAIT_W = $clog2(CPU_MAXW + 1);

  localparam logic [CC_W-1:0]   CC_LAST = CC_W'(CYCLE_LEN - 1);
  localparam logic [CC_W-1:0]   CC_ADV  = CC_W'(CYCLE_LEN - ADV);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAXW);

  // Grant encoding, one-hot {cpu, iv, rd}
  localparam logic [2:0] G_NONE = 3'b000;
  localparam logic [2:0] G_RD   = 3'b001;
  localparam logic [2:0] G_IV   = 3'b010;
  localparam logic [2:0] G_CPU  = 3'b100;

  // Slot sequencing state: OFF while disabled, FIRST during the partial slot
  // after enable (no slot-start pulse), RUN once the counter has wrapped.
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CC_W-1:0]     cc_q, cc_d;
  logic [2:0]          grant_q, grant_d;
  logic                cmd_we_q, cmd_we_d;
  logic [16:0]         cmd_adrs_q, cmd_adrs_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                alt_q, alt_d;
  logic                pend_q, pend_d;

  logic                cc_last;
  logic                decide;
  logic                slot_start;
  logic                bank_apply;
  logic [2:0]          sel;

  // Next-state logic: slot counter, arbitration, CPU starvation guard, bank.
  always_comb begin
    state_d    = state_q;
    cc_d       = cc_q;
    grant_d    = grant_q;
    cmd_we_d   = cmd_we_q;
    cmd_adrs_d = cmd_adrs_q;
    wait_d     = wait_q;
    alt_d      = alt_q;
    pend_d     = pend_q;
    sel        = G_NONE;

    cc_last = (cc_q == CC_LAST);
    decide  = en && cc_last;

    // Arbitration on the request levels of the decision clock. A CPU that
    // has already been passed over CPU_MAXW times wins outright.
    if (cpu_req && (wait_q >= WAIT_MAX)) begin
      sel = G_CPU;
    end else if (rd_req) begin
      sel = G_RD;
    end else if (iv_wr_req) begin
      sel = G_IV;
    end else if (cpu_req) begin
      sel = G_CPU;
    end

    // A pending bank swap lands on the slot boundary, or on the next clock
    // when the scheduler is disabled. The decision made on the same clock
    // still captures the old bank for its address.
    bank_apply = (pend_q || iv_frame_end) && (!en || decide);
    if (bank_apply) begin
      alt_d  = ~alt_q;
      pend_d = 1'b0;
    end else if (iv_frame_end) begin
      pend_d = 1'b1;
    end

    if (!en) begin
      state_d = S_OFF;
      cc_d    = '0;
      grant_d = G_NONE;
    end else begin
      cc_d = cc_last ? '0 : cc_q + CC_W'(1);
      if (state_q == S_OFF) begin
        state_d = S_FIRST;
      end else if (decide) begin
        state_d = S_RUN;
      end

      if (decide) begin
        grant_d = sel;
        unique case (sel)
          G_RD: begin
            cmd_we_d   = 1'b0;
            cmd_adrs_d = {~alt_q, rd_adrs};
          end
          G_IV: begin
            cmd_we_d   = 1'b1;
            cmd_adrs_d = {alt_q, iv_wr_adrs};
          end
          G_CPU: begin
            cmd_we_d   = cpu_we;
            cmd_adrs_d = cpu_adrs;
          end
          default: begin
            cmd_we_d   = 1'b0;
            cmd_adrs_d = '0;
          end
        endcase

        // Count slots the CPU asked for but did not get.
        if (!cpu_req || sel[2]) begin
          wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cc_q       <= '0;
      grant_q    <= G_NONE;
      cmd_we_q   <= 1'b0;
      cmd_adrs_q <= '0;
      wait_q     <= '0;
      alt_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cc_q       <= cc_d;
      grant_q    <= grant_d;
      cmd_we_q   <= cmd_we_d;
      cmd_adrs_q <= cmd_adrs_d;
      wait_q     <= wait_d;
      alt_q      <= alt_d;
      pend_q     <= pend_d;
    end
  end

  // Output decode: pulses come straight from registered state so reset
  // clears every output on the same clock.
  always_comb begin
    slot_start       = (state_q == S_RUN) && (cc_q == '0);
    fm_cycle_stp     = slot_start;
    fm_cycle_stp_adv = (cc_q == CC_ADV);
    grant            = grant_q;
    fm_cmd_valid     = slot_start && (grant_q != G_NONE);
    fm_cmd_we        = fm_cmd_valid ? cmd_we_q : 1'b0;
    fm_cmd_adrs      = fm_cmd_valid ? cmd_adrs_q : 17'd0;
    cpu_ack          = slot_start && grant_q[2];
    frame_alt        = alt_q;
  end

`ifdef FM_SCHED_STAT_EN
  // Index 0 rd, 1 iv, 2 cpu, 3 idle.
  logic [15:0] acc_q  [4];
  logic [15:0] acc_d  [4];
  logic [15:0] snap_q [4];
  logic [15:0] snap_d [4];
  logic [3:0]  stat_hit;

  // Per-frame slot accounting; the frame closes on the bank swap clock and
  // the slot decided on that clock counts towards the new frame.
  always_comb begin
    stat_hit = decide ? {(sel == G_NONE), sel} : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      acc_d[i]  = acc_q[i];
      snap_d[i] = snap_q[i];
      if (bank_apply) begin
        snap_d[i] = acc_q[i];
        acc_d[i]  = {15'd0, stat_hit[i]};
      end else if (stat_hit[i] && (acc_q[i] != 16'hFFFF)) begin
        acc_d[i] = acc_q[i] + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= acc_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign stat_rd   = snap_q[0];
  assign stat_iv   = snap_q[1];
  assign stat_cpu  = snap_q[2];
  assign stat_idle = snap_q[3];
`endif

endmodule

// File: tb/tb_fm_cycle_sched.sv
// ---------------------------------------------------------------------------
// tb_fm_cycle_sched -- directed + randomized bench for fm_cycle_sched.
// A slot-level reference model (elapsed-clock arithmetic, grant rules,
// bank bookkeeping) predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_fm_cycle_sched;

  localparam int CL   = 72;
  localparam int ADVL = 8;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] rd_adrs = '0;
  logic        iv_wr_req = 1'b0;
  logic [15:0] iv_wr_adrs = '0;
  logic        iv_frame_end = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [16:0] cpu_adrs = '0;

  logic        fm_cycle_stp_adv;
  logic        fm_cycle_stp;
  logic [2:0]  grant;
  logic        fm_cmd_valid;
  logic        fm_cmd_we;
  logic [16:0] fm_cmd_adrs;
  logic        cpu_ack;
  logic        frame_alt;

  fm_cycle_sched #(.CYCLE_LEN(CL), .ADV(ADVL), .CPU_MAXW(MAXW)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .rd_req           (rd_req),
    .rd_adrs          (rd_adrs),
    .iv_wr_req        (iv_wr_req),
    .iv_wr_adrs       (iv_wr_adrs),
    .iv_frame_end     (iv_frame_end),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_adrs         (cpu_adrs),
    .fm_cycle_stp_adv (fm_cycle_stp_adv),
    .fm_cycle_stp     (fm_cycle_stp),
    .grant            (grant),
    .fm_cmd_valid     (fm_cmd_valid),
    .fm_cmd_we        (fm_cmd_we),
    .fm_cmd_adrs      (fm_cmd_adrs),
    .cpu_ack          (cpu_ack),
    .frame_alt        (frame_alt)
  );

  always #4 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: k = clocks elapsed since enable, slot boundaries at
  // multiples of CL; the pending grant/command describes the current slot.
  int          k;
  logic [2:0]  m_grant;
  logic        m_we;
  logic [16:0] m_adrs;
  logic        m_alt;
  logic        m_pend;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at k=%0d t=%0t", tag, obs, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_grant = 3'b000;
    m_we    = 1'b0;
    m_adrs  = '0;
    m_alt   = 1'b0;
    m_pend  = 1'b0;
    m_wait  = 0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT sampled.
  task automatic model_edge();
    bit         swap;
    logic [2:0] g;
    if (rst) begin
      model_reset();
      return;
    end
    swap = m_pend || iv_frame_end;
    if (!en) begin
      k       = 0;
      m_grant = 3'b000;
      if (swap) begin
        m_alt  = ~m_alt;
        m_pend = 1'b0;
      end
      return;
    end
    if (k % CL == CL - 1) begin
      if (cpu_req && m_wait >= MAXW) g = 3'b100;
      else if (rd_req)               g = 3'b001;
      else if (iv_wr_req)            g = 3'b010;
      else if (cpu_req)              g = 3'b100;
      else                           g = 3'b000;
      m_grant = g;
      case (g)
        3'b001:  begin m_we = 1'b0;   m_adrs = {~m_alt, rd_adrs};   end
        3'b010:  begin m_we = 1'b1;   m_adrs = {m_alt, iv_wr_adrs}; end
        3'b100:  begin m_we = cpu_we; m_adrs = cpu_adrs;            end
        default: begin m_we = 1'b0;   m_adrs = '0;                  end
      endcase
      m_wait = (cpu_req && g != 3'b100) ? m_wait + 1 : 0;
      if (swap) begin
        m_alt  = ~m_alt;
        m_pend = 1'b0;
      end
    end else if (iv_frame_end) begin
      m_pend = 1'b1;
    end
    k++;
  endtask

  task automatic check_all();
    bit start;
    bit cmd;
    start = (k > 0) && (k % CL == 0);
    cmd   = start && (m_grant != 3'b000);
    chk("stp",   32'(fm_cycle_stp),     32'(start));
    chk("adv",   32'(fm_cycle_stp_adv), 32'(k % CL == CL - ADVL));
    chk("grant", 32'(grant),            32'(m_grant));
    chk("valid", 32'(fm_cmd_valid),     32'(cmd));
    chk("we",    32'(fm_cmd_we),        32'(cmd ? m_we : 1'b0));
    chk("adrs",  32'(fm_cmd_adrs),      32'(cmd ? m_adrs : 17'd0));
    chk("ack",   32'(cpu_ack),          32'(start && m_grant == 3'b100));
    chk("alt",   32'(frame_alt),        32'(m_alt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int n;
    model_reset();

    // Reset: every output low.
    #2 rst = 1'b1;
    #1 check_all();
    tick();
    tick();
    #1 rst = 1'b0;

    // Enabled with no requests: pulses only, no grants or commands.
    en = 1'b1;
    repeat (3 * CL) tick();

    // rd and iv both held: rd wins, display bank is ~frame_alt.
    rd_req = 1'b1; iv_wr_req = 1'b1; rd_adrs = 16'h1234; iv_wr_adrs = 16'h5555;
    repeat (2 * CL) tick();

    // iv alone: write into the current bank.
    rd_req = 1'b0; iv_wr_adrs = 16'h00FF;
    repeat (2 * CL) tick();

    // rd and cpu held: cpu forced in after MAXW denials.
    iv_wr_req = 1'b0; rd_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_adrs = 17'h1ABCD;
    repeat (7 * CL) tick();

    // Frame end at cc=70 with an iv grant pending.
    rd_req = 1'b0; cpu_req = 1'b0; iv_wr_req = 1'b1; iv_wr_adrs = 16'h0F0F;
    for (int i = 0; i < 2 * CL && (k % CL) != 70; i++) tick();
    iv_frame_end = 1'b1;
    tick();
    iv_frame_end = 1'b0;
    repeat (2 * CL) tick();

    // Randomized traffic, including frame-end pulses and enable drops.
    for (int c = 0; c < 30 * CL; c++) begin
      if ($urandom_range(0, 19) == 0) rd_req    = ~rd_req;
      if ($urandom_range(0, 19) == 0) iv_wr_req = ~iv_wr_req;
      if ($urandom_range(0, 24) == 0) cpu_req   = ~cpu_req;
      rd_adrs      = 16'($urandom);
      iv_wr_adrs   = 16'($urandom);
      cpu_adrs     = 17'($urandom);
      cpu_we       = 1'($urandom);
      iv_frame_end = ($urandom_range(0, 119) == 0);
      if (en) begin
        if ($urandom_range(0, 899) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 29) == 0) en = 1'b1;
      end
      tick();
    end
    iv_frame_end = 1'b0;

    // Reset in the middle of a granted slot, then first slot timing.
    en = 1'b1; rd_req = 1'b1; cpu_req = 1'b0; iv_wr_req = 1'b0;
    for (int i = 0; i < 4 * CL && !((k % CL) == 30 && k > CL); i++) tick();
    #1 rst = 1'b1;
    #1 model_reset();
    check_all();
    tick();
    tick();
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * CL; i++) begin
      tick();
      n++;
      if (fm_cycle_stp) break;
    end
    chk("first_stp_latency", 32'(n), 32'(CL));
    repeat (2 * CL) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
